mc_apb_master: RTL and testbench

MC_APB_MASTER -- requirements
Module: mc_apb_master

---
 rtl/mc_apb_master_if.sv | 32 +++
 rtl/mc_apb_master.sv | 135 +++++++++++++
 tb/tb_mc_apb_master.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_apb_master_if.sv
// Command, APB and response signal bundle for mc_apb_master.
// The master modport is the design side; slave is the requester/APB-slave side.
interface mc_apb_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    output cmd_ready, psel, penable, pwrite, paddr, pwdata,
    output rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    input  cmd_ready, psel, penable, pwrite, paddr, pwdata,
    input  rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/mc_apb_master.sv
// APB master fed by a command FIFO; returns one response pulse per transfer, in order.
// Define MC_APB_TIMEOUT_EN to build the ACCESS-phase wait counter and timeout abort.
module mc_apb_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int TO_CYCLES  = 255
) (
  input logic             pclk,
  input logic             presetn,
  mc_apb_master_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TO_CYCLES < 1 || TO_CYCLES > 255) begin : g_param_check
    $error("mc_apb_master: FIFO_DEPTH or TO_CYCLES out of range");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state, state_nxt;
  logic [64:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full, fifo_empty, push, pop;
  logic [31:0]   paddr_q, pwdata_q, rdata_q;
  logic          pwrite_q, rsp_valid_q;
  logic          xfer_ok, xfer_abort, xfer_done;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = bus.cmd_valid && !fifo_full;
  assign xfer_ok    = (state == ACCESS) && bus.pready;
  assign xfer_done  = xfer_ok || xfer_abort;

  // Storage is not reset; reset flushes the FIFO by clearing the pointers and count.
  always_ff @(posedge pclk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Completion pops the next entry directly so back-to-back transfers skip IDLE.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (xfer_done) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = SETUP;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      if (pop) {pwrite_q, paddr_q, pwdata_q} <= fifo_mem[rd_ptr];
      rsp_valid_q <= xfer_done;
      if (xfer_done) rdata_q <= (xfer_ok && !pwrite_q) ? bus.prdata : 32'h0;
    end
  end

`ifdef MC_APB_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       rsp_err_q;

  // pready on the cycle the count hits the limit still wins over the abort.
  assign xfer_abort = (state == ACCESS) && !bus.pready && (wait_cnt == 8'(TO_CYCLES));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state == SETUP)                         wait_cnt <= '0;
      else if (state == ACCESS && !bus.pready)    wait_cnt <= wait_cnt + 8'd1;
      rsp_err_q <= xfer_abort;
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign xfer_abort  = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.cmd_ready = !fifo_full;
  assign bus.busy      = !fifo_empty || (state != IDLE);
  assign bus.psel      = (state == SETUP) || (state == ACCESS);
  assign bus.penable   = (state == ACCESS);
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_mc_apb_master.sv
// Scoreboard bench for mc_apb_master: commands push expected APB setups and responses,
// independent monitors pop and compare them as the design presents them.
module tb_mc_apb_master;
  logic pclk = 1'b0;
  logic presetn;

  always #5 pclk = ~pclk;

  mc_apb_master_if ifc ();

  mc_apb_master #(
    .FIFO_DEPTH(4),
    .TO_CYCLES (8)
  ) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .bus    (ifc)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } apb_t;

  rsp_t rspQ[$];
  apb_t apbQ[$];

  int testsRun    = 0;
  int testsFailed = 0;
  int slaveWait   = 0;
  bit slaveStuck  = 1'b0;
  bit stuckAddrEn = 1'b0;
  int accCnt      = 0;
  int idleCycles  = 0;
  int penCycles   = 0;
  int stuckPen    = 0;
  bit prevRsp     = 1'b0;

  // Simple APB slave: pready after slaveWait low ACCESS cycles; data derived from address.
  always @(posedge pclk) begin
    if (ifc.psel && ifc.penable && !ifc.pready) accCnt <= accCnt + 1;
    else                                       accCnt <= 0;
  end

  assign ifc.pready = !slaveStuck && !(stuckAddrEn && ifc.paddr == 32'h30) && (accCnt >= slaveWait);
  assign ifc.prdata = (ifc.paddr == 32'h10) ? 32'hDEADBEEF : {ifc.paddr[15:0], 16'hC0DE};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expRdata, input logic expErr);
    int guard = 0;
    rsp_t r;
    apb_t a;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_write = wr;
    ifc.cmd_addr  = addr;
    ifc.cmd_wdata = wdata;
    while (!ifc.cmd_ready && guard < 300) begin
      @(negedge pclk);
      guard++;
    end
    checkOutput("cmd_ready_at_issue", {31'b0, ifc.cmd_ready}, 32'd1);
    if (ifc.cmd_ready) begin
      a.addr  = addr;
      a.wr    = wr;
      a.wdata = wdata;
      apbQ.push_back(a);
      r.rdata = expRdata;
      r.err   = expErr;
      rspQ.push_back(r);
      @(posedge pclk);
      @(negedge pclk);
    end
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int guard = 0;
    while ((ifc.busy || rspQ.size() != 0) && guard < 500) begin
      @(negedge pclk);
      guard++;
    end
    checkOutput("drain_busy", {31'b0, ifc.busy}, 32'd0);
    checkOutput("drain_rsp_pending", rspQ.size(), 32'd0);
    @(negedge pclk);
  endtask

  // APB monitor checks each SETUP phase; response monitor checks each rsp_valid pulse.
  always @(negedge pclk) begin
    apb_t ea;
    rsp_t er;
    if (presetn) begin
      if (ifc.psel && !ifc.penable) begin
        checkOutput("apb_setup_expected", {31'b0, apbQ.size() != 0}, 32'd1);
        if (apbQ.size() != 0) begin
          ea = apbQ.pop_front();
          checkOutput("apb_paddr", ifc.paddr, ea.addr);
          checkOutput("apb_pwrite", {31'b0, ifc.pwrite}, {31'b0, ea.wr});
          if (ea.wr) checkOutput("apb_pwdata", ifc.pwdata, ea.wdata);
        end
      end
      if (ifc.psel && ifc.penable) begin
        penCycles++;
        if (ifc.paddr == 32'h30) stuckPen++;
      end
      if (!ifc.psel && ifc.busy) idleCycles++;
      if (ifc.rsp_valid) begin
        checkOutput("rsp_back_to_back", {31'b0, prevRsp}, 32'd0);
        checkOutput("rsp_expected", {31'b0, rspQ.size() != 0}, 32'd1);
        if (rspQ.size() != 0) begin
          er = rspQ.pop_front();
          checkOutput("rsp_rdata", ifc.rsp_rdata, er.rdata);
          checkOutput("rsp_err", {31'b0, ifc.rsp_err}, {31'b0, er.err});
        end
      end
      prevRsp = ifc.rsp_valid;
    end else begin
      prevRsp = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ifc.cmd_valid = 1'b0;
    ifc.cmd_write = 1'b0;
    ifc.cmd_addr  = '0;
    ifc.cmd_wdata = '0;
    presetn       = 1'b0;
    #1;
    checkOutput("reset_psel", {31'b0, ifc.psel}, 32'd0);
    checkOutput("reset_penable", {31'b0, ifc.penable}, 32'd0);
    checkOutput("reset_pwrite", {31'b0, ifc.pwrite}, 32'd0);
    checkOutput("reset_paddr", ifc.paddr, 32'd0);
    checkOutput("reset_pwdata", ifc.pwdata, 32'd0);
    checkOutput("reset_rsp_valid", {31'b0, ifc.rsp_valid}, 32'd0);
    checkOutput("reset_rsp_err", {31'b0, ifc.rsp_err}, 32'd0);
    checkOutput("reset_rsp_rdata", ifc.rsp_rdata, 32'd0);
    checkOutput("reset_cmd_ready", {31'b0, ifc.cmd_ready}, 32'd1);
    checkOutput("reset_busy", {31'b0, ifc.busy}, 32'd0);
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);

    // Single write with pready high: SETUP at k+1, ACCESS at k+2, response at k+3.
    slaveWait = 0;
    applyStimulus(1'b1, 32'h0000_0008, 32'h1234_5678, 32'h0, 1'b0);
    checkOutput("lat_k_psel", {31'b0, ifc.psel}, 32'd0);
    checkOutput("lat_k_busy", {31'b0, ifc.busy}, 32'd1);
    @(negedge pclk);
    checkOutput("lat_k1_psel", {31'b0, ifc.psel}, 32'd1);
    checkOutput("lat_k1_penable", {31'b0, ifc.penable}, 32'd0);
    checkOutput("lat_k1_paddr", ifc.paddr, 32'h8);
    checkOutput("lat_k1_pwdata", ifc.pwdata, 32'h1234_5678);
    @(negedge pclk);
    checkOutput("lat_k2_penable", {31'b0, ifc.penable}, 32'd1);
    checkOutput("lat_k2_rsp_valid", {31'b0, ifc.rsp_valid}, 32'd0);
    @(negedge pclk);
    checkOutput("lat_k3_rsp_valid", {31'b0, ifc.rsp_valid}, 32'd1);
    checkOutput("lat_k3_psel", {31'b0, ifc.psel}, 32'd0);
    waitIdle();
    checkOutput("idle_paddr_held", ifc.paddr, 32'h8);

    // Read with three wait states: penable high for four cycles.
    slaveWait = 3;
    penCycles = 0;
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    waitIdle();
    checkOutput("read_penable_cycles", penCycles, 32'd4);

    // Five commands against a stalled slave: FIFO fills, then drains with no idle gap.
    slaveWait  = 0;
    slaveStuck = 1'b1;
    applyStimulus(1'b1, 32'h20, 32'hA0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h24, 32'h0, 32'h0024_C0DE, 1'b0);
    applyStimulus(1'b1, 32'h28, 32'hA2, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h2C, 32'h0, 32'h002C_C0DE, 1'b0);
    applyStimulus(1'b1, 32'h40, 32'hA4, 32'h0, 1'b0);
    checkOutput("full_cmd_ready", {31'b0, ifc.cmd_ready}, 32'd0);
    checkOutput("full_busy", {31'b0, ifc.busy}, 32'd1);
    idleCycles = 0;
    slaveWait  = 1;
    slaveStuck = 1'b0;
    waitIdle();
    checkOutput("burst_idle_cycles", idleCycles, 32'd0);
    checkOutput("drained_cmd_ready", {31'b0, ifc.cmd_ready}, 32'd1);

    // Pushes landing on the pop of the last entry keep order.
    slaveWait = 0;
    applyStimulus(1'b0, 32'h50, 32'h0, 32'h0050_C0DE, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b1, 32'h54, 32'hFFFF_0001, 32'h0, 1'b0);
    waitIdle();

`ifdef MC_APB_TIMEOUT_EN
    // Stuck slave on 0x30: eight wait cycles then abort; the queued read proceeds.
    stuckAddrEn = 1'b1;
    stuckPen    = 0;
    applyStimulus(1'b1, 32'h30, 32'h55, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h34, 32'h0, 32'h0034_C0DE, 1'b0);
    waitIdle();
    checkOutput("timeout_penable_cycles", stuckPen, 32'd9);
    stuckAddrEn = 1'b0;
`endif

    // Reset during ACCESS with two entries queued: everything clears, no response.
    slaveStuck = 1'b1;
    applyStimulus(1'b0, 32'h60, 32'h0, 32'h0060_C0DE, 1'b0);
    applyStimulus(1'b1, 32'h64, 32'h11, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h68, 32'h22, 32'h0, 1'b0);
    checkOutput("pre_reset_penable", {31'b0, ifc.penable}, 32'd1);
    #2;
    presetn = 1'b0;
    rspQ.delete();
    apbQ.delete();
    #1;
    checkOutput("mid_reset_psel", {31'b0, ifc.psel}, 32'd0);
    checkOutput("mid_reset_penable", {31'b0, ifc.penable}, 32'd0);
    checkOutput("mid_reset_busy", {31'b0, ifc.busy}, 32'd0);
    checkOutput("mid_reset_cmd_ready", {31'b0, ifc.cmd_ready}, 32'd1);
    checkOutput("mid_reset_paddr", ifc.paddr, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      checkOutput("mid_reset_rsp_valid", {31'b0, ifc.rsp_valid}, 32'd0);
    end
    presetn    = 1'b1;
    slaveStuck = 1'b0;
    @(negedge pclk);
    checkOutput("post_reset_rsp_valid", {31'b0, ifc.rsp_valid}, 32'd0);
    applyStimulus(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    waitIdle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
